// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD frame streamer.
// Holds the RGB565 palette, border white and the FSM state encoding.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } lcd_state_t;

    localparam logic [15:0] PAL_YELLOW = 16'hFFE0;
    localparam logic [15:0] PAL_LBLUE  = 16'h07FF;
    localparam logic [15:0] PAL_RED    = 16'hF800;
    localparam logic [15:0] PAL_PURPLE = 16'h780F;
    localparam logic [15:0] PAL_BLACK  = 16'h0000;
    localparam logic [15:0] PAL_DBLUE  = 16'h001F;

    localparam logic [15:0] WHITE_565 = 16'hFFFF;
    localparam logic [17:0] WHITE_666 = 18'h3FFFF;

    // Counter width for a range of n values (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index 5 and above (including any out-of-range mood) is dark blue.
    function automatic logic [15:0] palette565(input logic [31:0] idx);
        case (idx)
            32'd0:   return PAL_YELLOW;
            32'd1:   return PAL_LBLUE;
            32'd2:   return PAL_RED;
            32'd3:   return PAL_PURPLE;
            32'd4:   return PAL_BLACK;
            default: return PAL_DBLUE;
        endcase
    endfunction

    // 5-bit red/blue channels gain their MSB as a new LSB; green is kept.
    function automatic logic [17:0] rgb565_to_666(input logic [15:0] c);
        return {c[15:11], c[15], c[10:5], c[4:0], c[4]};
    endfunction

endpackage

// File: rtl/lcd_xy_counter.sv
// lcd_xy_counter: pixel x/y position for one frame.
// Ports: clk, rst (async, active-low), clr (zero x/y), adv (step one pixel),
//        x, y (current position), last (position is the final pixel).
module lcd_xy_counter
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    localparam int XW = cnt_w(H_RES),
    localparam int YW = cnt_w(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/lcd_frame_streamer.sv
// lcd_frame_streamer: streams a solid or checkerboard frame in a palette colour.
// Ports: clk, rst (async, active-low), mood_sel, pattern_sel, refresh (inputs);
//        pix_data/pix_valid/pix_last with pix_ready handshake; frame_done, busy.
// Option: define LCD_FRAME_BORDER_EN to paint a one-pixel white frame border.
module lcd_frame_streamer
    import lcd_pkg::*;
#(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int PIXEL_W    = 16,
    parameter int NUM_MOODS  = 8,
    parameter int CHECK_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_MOODS)-1:0] mood_sel,
    input  logic                         pattern_sel,
    input  logic                         refresh,
    output logic [PIXEL_W-1:0]           pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         pix_last,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int MW = $clog2(NUM_MOODS);
    localparam int XW = cnt_w(H_RES);
    localparam int YW = cnt_w(V_RES);

    lcd_state_t state, state_nx;

    logic [MW-1:0] mood_q;
    logic          pat_q;
    logic          refresh_pending;
    logic          pending;
    logic          load;
    logic          adv;
    logic          last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    lcd_xy_counter #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_xy (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .adv (adv),
        .x   (x),
        .y   (y),
        .last(last)
    );

    // Settings that differ from the last-drawn frame also count as a redraw.
    assign pending = refresh_pending
                   || (mood_sel != mood_q)
                   || (pattern_sel != pat_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        pix_valid  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b1;
        unique case (state)
            IDLE: begin
                if (pending) state_nx = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                busy     = 1'b1;
                state_nx = STREAM;
            end
            STREAM: begin
                pix_valid  = 1'b1;
                busy       = 1'b1;
                frame_done = 1'b0;
                if (pix_ready && last) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign adv = pix_valid && pix_ready;

    // A refresh arriving in any state, even the LOAD cycle, is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mood_q          <= '0;
            pat_q           <= 1'b0;
            refresh_pending <= 1'b1;
        end else begin
            if (load) begin
                mood_q <= mood_sel;
                pat_q  <= pattern_sel;
            end
            if (refresh)   refresh_pending <= 1'b1;
            else if (load) refresh_pending <= 1'b0;
        end
    end

    logic [15:0]        pal565;
    logic [15:0]        base565;
    logic [XW-1:0]      xs;
    logic [YW-1:0]      ys;
    logic               dark;
    logic [PIXEL_W-1:0] fill;
    logic [PIXEL_W-1:0] color;

    assign pal565 = palette565(32'(mood_q));

    // Square parity: bit 0 of the coordinates scaled down by the edge size.
    assign xs   = (x >> CHECK_LOG2) & XW'(1);
    assign ys   = (y >> CHECK_LOG2) & YW'(1);
    assign dark = pat_q && ((|xs) ^ (|ys));

    assign base565 = dark ? PAL_BLACK : pal565;
    assign fill    = (PIXEL_W == 18) ? PIXEL_W'(rgb565_to_666(base565))
                                     : PIXEL_W'(base565);

`ifdef LCD_FRAME_BORDER_EN
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    logic               border;
    logic [PIXEL_W-1:0] white;

    assign white  = (PIXEL_W == 18) ? PIXEL_W'(WHITE_666)
                                    : PIXEL_W'(WHITE_565);
    assign border = (x == '0) || (x == X_MAX)
                 || (y == '0) || (y == Y_MAX);
    assign color  = border ? white : fill;
`else
    assign color = fill;
`endif

    assign pix_data = pix_valid ? color : '0;
    assign pix_last = pix_valid && last;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb_lcd_frame_streamer: directed bench with a frame-level reference model.
// Two instances: 4x3 solid/refresh/reset scenarios and an 8x4 checkerboard.
`timescale 1ns/1ps
module tb_lcd_frame_streamer;

    localparam int HA = 4, VA = 3, CLA = 4, NMA = 6;
    localparam int HB = 8, VB = 4, CLB = 1, NMB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, pat_a, refresh_a, ready_a;
    logic        valid_a, last_a, done_a, busy_a;
    logic [2:0]  mood_a;
    logic [15:0] data_a;

    logic        rst_b, pat_b, refresh_b, ready_b;
    logic        valid_b, last_b, done_b, busy_b;
    logic [2:0]  mood_b;
    logic [15:0] data_b;

    lcd_frame_streamer #(
        .H_RES(HA), .V_RES(VA), .PIXEL_W(16),
        .NUM_MOODS(NMA), .CHECK_LOG2(CLA)
    ) dut_a (
        .clk(clk), .rst(rst_a), .mood_sel(mood_a),
        .pattern_sel(pat_a), .refresh(refresh_a),
        .pix_data(data_a), .pix_valid(valid_a),
        .pix_ready(ready_a), .pix_last(last_a),
        .frame_done(done_a), .busy(busy_a)
    );

    lcd_frame_streamer #(
        .H_RES(HB), .V_RES(VB), .PIXEL_W(16),
        .NUM_MOODS(NMB), .CHECK_LOG2(CLB)
    ) dut_b (
        .clk(clk), .rst(rst_b), .mood_sel(mood_b),
        .pattern_sel(pat_b), .refresh(refresh_b),
        .pix_data(data_b), .pix_valid(valid_b),
        .pix_ready(ready_b), .pix_last(last_b),
        .frame_done(done_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is H*V accepted pixels drawn with the
    // settings present on the inputs during the cycle before it starts.
    int          idx[2], frames[2], gap[2], last_gap[2], fm[2], pin_m[2];
    bit          in_frame[2], stall[2], fp[2], pin_p[2];
    logic [15:0] sd[2];
    logic        sl[2];
    logic [15:0] cap[2][64];

    function automatic logic [15:0] pal(input int m);
        case (m)
            0: return 16'hFFE0;
            1: return 16'h07FF;
            2: return 16'hF800;
            3: return 16'h780F;
            4: return 16'h0000;
            default: return 16'h001F;
        endcase
    endfunction

    function automatic logic [15:0] exp_px(input int h, input int v,
                                           input int cl, input int m,
                                           input bit p, input int i);
        int x = i % h;
        int y = i / h;
        logic [15:0] c = pal(m);
        if (p && ((((x >> cl) ^ (y >> cl)) & 1) == 1)) c = 16'h0000;
`ifdef LCD_FRAME_BORDER_EN
        if (x == 0 || x == h - 1 || y == 0 || y == v - 1) c = 16'hFFFF;
`endif
        return c;
    endfunction

    task automatic scb(input int d, input int h, input int v, input int cl,
                       input logic rn, input logic vld, input logic rdy,
                       input logic lst, input logic fd,
                       input logic [15:0] dat, input int m, input bit p);
        int n = h * v;
        if (!rn) begin
            in_frame[d] = 0;
            idx[d] = 0;
            stall[d] = 0;
        end else if (vld) begin
            check("valid_with_done", 32'(fd), 32'd0);
            if (!in_frame[d]) begin
                in_frame[d] = 1;
                idx[d] = 0;
                fm[d] = pin_m[d];
                fp[d] = pin_p[d];
                last_gap[d] = gap[d];
            end
            if (stall[d]) begin
                check("stall_data", 32'(dat), 32'(sd[d]));
                check("stall_last", 32'(lst), 32'(sl[d]));
            end
            check("pix_data", 32'(dat),
                  32'(exp_px(h, v, cl, fm[d], fp[d], idx[d])));
            check("pix_last", 32'(lst), 32'(idx[d] == n - 1));
            cap[d][idx[d] % 64] = dat;
            if (rdy) begin
                stall[d] = 0;
                if (idx[d] == n - 1) begin
                    in_frame[d] = 0;
                    idx[d] = 0;
                    frames[d]++;
                    gap[d] = 0;
                end else begin
                    idx[d]++;
                end
            end else begin
                stall[d] = 1;
                sd[d] = dat;
                sl[d] = lst;
            end
        end else begin
            gap[d]++;
            check("done_when_idle", 32'(fd), 32'd1);
        end
        pin_m[d] = m;
        pin_p[d] = p;
    endtask

    always @(negedge clk) begin
        scb(0, HA, VA, CLA, rst_a, valid_a, ready_a, last_a, done_a,
            data_a, int'(mood_a), pat_a);
        scb(1, HB, VB, CLB, rst_b, valid_b, ready_b, last_b, done_b,
            data_b, int'(mood_b), pat_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int d, input int target,
                               input int budget);
        int n = 0;
        while (frames[d] < target && n < budget) begin
            tick();
            n++;
        end
        check("frame_timeout", 32'(frames[d] >= target), 32'd1);
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(in_frame[0] && idx[0] >= target) && n < 60) begin
            tick();
            n++;
        end
        check("idx_timeout", 32'(idx[0] >= target), 32'd1);
    endtask

    task automatic rand_frame(input int target);
        int n = 0;
        while (frames[0] < target && n < 400) begin
            ready_a = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready_a = 1'b1;
        check("rand_timeout", 32'(frames[0] >= target), 32'd1);
    endtask

    initial begin
        int f;
        logic [15:0] row0 [8];
        row0 = '{16'hFFE0, 16'hFFE0, 16'h0000, 16'h0000,
                 16'hFFE0, 16'hFFE0, 16'h0000, 16'h0000};
        rst_a = 0; mood_a = 3'd2; pat_a = 0; refresh_a = 0; ready_a = 1;
        rst_b = 0; mood_b = 3'd0; pat_b = 1; refresh_b = 0; ready_b = 0;
        repeat (3) tick();
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst_a = 1;
        rst_b = 1;

        wait_frames(0, 1, 50);
        check("f1_done", 32'(done_a), 32'd1);
        check("f1_valid_off", 32'(valid_a), 32'd0);
`ifdef LCD_FRAME_BORDER_EN
        for (int i = 0; i < 12; i++)
            check("border_px", 32'(cap[0][i]),
                  (i == 5 || i == 6) ? 32'hF800 : 32'hFFFF);
`else
        check("f1_first", 32'(cap[0][0]), 32'hF800);
        check("f1_last", 32'(cap[0][11]), 32'hF800);
`endif
        check("f1_mid", 32'(cap[0][5]), 32'hF800);
        repeat (5) tick();
        check("idle_frames", 32'(frames[0]), 32'd1);
        check("idle_busy", 32'(busy_a), 32'd0);

        refresh_a = 1; tick(); refresh_a = 0;
        rand_frame(2);
        check("f2_mid", 32'(cap[0][6]), 32'hF800);
        repeat (3) tick();

        mood_a = 3'd1;
        wait_idx(5);
        mood_a = 3'd3;
        wait_frames(0, 3, 50);
        check("f3_tail", 32'(cap[0][6]), 32'h07FF);
        wait_frames(0, 4, 50);
        check("f4_mood", 32'(cap[0][5]), 32'h780F);
        check("f4_gap", 32'(last_gap[0] <= 3), 32'd1);
        repeat (3) tick();

        mood_a = 3'd7;
        wait_frames(0, 5, 50);
        check("oor_mood", 32'(cap[0][5]), 32'h001F);
        repeat (3) tick();

        refresh_a = 1; tick(); refresh_a = 0;
        wait_frames(0, 6, 50);
        check("in_done_busy", 32'(busy_a), 32'd0);
        refresh_a = 1; tick(); refresh_a = 0;
        wait_frames(0, 7, 50);
        check("done_refresh", 32'(cap[0][5]), 32'h001F);
        repeat (3) tick();

        mood_a = 3'd4;
        wait_idx(7);
        rst_a = 0;
        #1;
        check("abort_valid", 32'(valid_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        mood_a = 3'd0;
        f = frames[0];
        repeat (2) tick();
        check("rst_hold_valid", 32'(valid_a), 32'd0);
        rst_a = 1;
        wait_frames(0, f + 1, 50);
        check("post_rst_mood", 32'(cap[0][5]), 32'hFFE0);
        check("post_rst_frames", 32'(frames[0]), 32'(f + 1));

        ready_b = 1;
        wait_frames(1, 1, 100);
`ifdef LCD_FRAME_BORDER_EN
        check("chk_b_corner", 32'(cap[1][0]), 32'hFFFF);
        check("chk_b_in0", 32'(cap[1][9]), 32'hFFE0);
        check("chk_b_in1", 32'(cap[1][10]), 32'h0000);
`else
        for (int i = 0; i < 8; i++) begin
            check("chk_row0", 32'(cap[1][i]), 32'(row0[i]));
            check("chk_row2", 32'(cap[1][16 + i]),
                  32'(row0[i] ^ 16'hFFE0));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
